tm1638_responder: RTL and testbench

TM1638_RESPONDER -- requirements
Module: tm1638_responder

---
 rtl/tm1638_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// ---------------------------------------------------------------------------
// tm1638_responder
//   Target-side model of a TM1638 LED/key board controller. It decodes the
//   three-wire serial protocol (strobe, clock, data; LSB first) and keeps
//   the display RAM and the display control registers. On a key-read
//   command it shifts a latched key image back out.
//
// Ports
//   clk, rst      system clock; asynchronous active-high reset
//   sio_clk       serial clock from the controller (idles high)
//   sio_stb       active-low transaction strobe
//   sio_data_in   serial data from the controller
//   sio_data_out  serial read data toward the controller
//   sio_data_oe   drive enable for sio_data_out (tristate resolved above)
//   keys          key-scan image; read byte k = keys[8k+7:8k]
//   disp_ram      16-byte display RAM; address a = disp_ram[8a+7:8a]
//   disp_on       display enable
//   brightness    brightness level
//   frame_done    one-clk pulse when a write window that wrote data closes
// ---------------------------------------------------------------------------
module tm1638_responder #(
    parameter int SYNC_STAGES = 2   // synchronizer depth, must be >= 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sio_clk,
    input  logic         sio_stb,
    input  logic         sio_data_in,
    output logic         sio_data_out,
    output logic         sio_data_oe,
    input  logic [31:0]  keys,
    output logic [127:0] disp_ram,
    output logic         disp_on,
    output logic [2:0]   brightness,
    output logic         frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_KEYS,
        IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] stb_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   sclk_prev_q;
    logic                   stb_prev_q;

    logic sclk_s, stb_s, din_s;
    logic sclk_rise, sclk_fall, stb_rise, stb_fall;

    // The strobe chain resets low: if rst drops while the controller is in
    // the middle of a window (strobe still low), no falling edge is seen
    // until the strobe has gone high and come back down, so the abandoned
    // transaction is never decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '1;
            stb_sync_q  <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b1;
            stb_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sio_clk};
            stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], sio_stb};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], sio_data_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            stb_prev_q  <= stb_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign stb_s     = stb_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign stb_rise  =  stb_s  & ~stb_prev_q;
    assign stb_fall  = ~stb_s  &  stb_prev_q;

    // ------------------------------------------------------------------
    // Protocol FSM and register file
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shreg_q;
    logic [3:0]        ptr_q;
    logic              fixed_q;      // 1: fixed address, 0: auto-increment
    logic              wrote_q;      // at least one byte written this window
    logic [31:0]       keys_q;
    logic [5:0]        rd_cnt_q;     // index of next key bit to present
    logic              rd_active_q;  // first read bit already presented
    logic [15:0][7:0]  ram_q;
    logic              disp_on_q;
    logic [2:0]        bright_q;
    logic              oe_q;
    logic              dout_q;
    logic              frame_q;

    // Byte as it stands once the current sample is shifted in (LSB first).
    logic [7:0] byte_w;
    assign byte_w = {din_s, shreg_q[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            ptr_q       <= '0;
            fixed_q     <= 1'b0;
            wrote_q     <= 1'b0;
            keys_q      <= '0;
            rd_cnt_q    <= '0;
            rd_active_q <= 1'b0;
            ram_q       <= '0;
            disp_on_q   <= 1'b0;
            bright_q    <= '0;
            oe_q        <= 1'b0;
            dout_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (stb_rise) begin
                // End of window from any state: drop any partial byte and
                // release the data line.
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
                dout_q    <= 1'b0;
                frame_q   <= (state_q == WR_DATA) && wrote_q;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (stb_fall) begin
                            state_q   <= CMD;
                            bit_cnt_q <= '0;
                        end
                    end

                    CMD: begin
                        if (sclk_rise) begin
                            shreg_q   <= byte_w;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (byte_w[7:6])
                                    2'b01: begin
                                        fixed_q <= byte_w[2];
                                        if (byte_w[1]) begin
                                            keys_q      <= keys;
                                            rd_cnt_q    <= '0;
                                            rd_active_q <= 1'b0;
                                            state_q     <= RD_KEYS;
                                        end else begin
                                            state_q <= IGNORE;
                                        end
                                    end
                                    2'b10: begin
                                        disp_on_q <= byte_w[3];
                                        bright_q  <= byte_w[2:0];
                                        state_q   <= IGNORE;
                                    end
                                    2'b11: begin
                                        ptr_q   <= byte_w[3:0];
                                        wrote_q <= 1'b0;
                                        state_q <= WR_DATA;
                                    end
                                    default: state_q <= IGNORE;
                                endcase
                            end
                        end
                    end

                    WR_DATA: begin
                        if (sclk_rise) begin
                            shreg_q   <= byte_w;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                ram_q[ptr_q] <= byte_w;
                                wrote_q      <= 1'b1;
                                if (!fixed_q)
                                    ptr_q <= ptr_q + 4'd1;   // 15 wraps to 0
                            end
                        end
                    end

                    RD_KEYS: begin
                        // Bits change on falling edges so they are stable
                        // when the controller samples on the rising edge.
                        if (sclk_fall) begin
                            if (!rd_active_q) begin
                                oe_q        <= 1'b1;
                                dout_q      <= keys_q[0];
                                rd_cnt_q    <= 6'd1;
                                rd_active_q <= 1'b1;
                            end else if (rd_cnt_q == 6'd32) begin
                                oe_q    <= 1'b0;
                                dout_q  <= 1'b0;
                                state_q <= IGNORE;
                            end else begin
                                dout_q   <= keys_q[rd_cnt_q[4:0]];
                                rd_cnt_q <= rd_cnt_q + 6'd1;
                            end
                        end
                    end

                    IGNORE: ;

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign disp_ram     = ram_q;
    assign disp_on      = disp_on_q;
    assign brightness   = bright_q;
    assign sio_data_oe  = oe_q;
    assign sio_data_out = dout_q;
    assign frame_done   = frame_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder. Stimulus pushes expected RAM images
// (checked at each frame_done pulse) and expected read bits (checked when
// the controller samples on sio_clk rising with the drive enable high).
module tb_tm1638_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sio_clk = 1'b1;
    logic         sio_stb = 1'b1;
    logic         sio_data_in = 1'b0;
    logic         sio_data_out;
    logic         sio_data_oe;
    logic [31:0]  keys = '0;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   brightness;
    logic         frame_done;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .sio_clk(sio_clk), .sio_stb(sio_stb), .sio_data_in(sio_data_in),
        .sio_data_out(sio_data_out), .sio_data_oe(sio_data_oe),
        .keys(keys), .disp_ram(disp_ram), .disp_on(disp_on),
        .brightness(brightness), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [127:0] frame_q[$];
    logic         bit_q[$];
    logic [15:0][7:0] exp_ram = '0;
    logic         prev_fd = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame monitor: each pulse must be one clk wide and match the next
    // expected RAM image.
    always @(negedge clk) begin
        if (frame_done) begin
            chk("frame_done_width", {127'd0, prev_fd}, 128'd0);
            if (frame_q.size() == 0)
                chk("frame_done_unexpected", 128'd1, 128'd0);
            else
                chk("frame_ram", disp_ram, frame_q.pop_front());
        end
        prev_fd <= frame_done;
    end

    // Read monitor: controller samples on its rising clock edge.
    always @(posedge sio_clk) begin
        if (sio_data_oe) begin
            if (bit_q.size() == 0)
                chk("read_bit_extra", 128'd1, 128'd0);
            else
                chk("read_bit", {127'd0, sio_data_out}, {127'd0, bit_q.pop_front()});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stb_lo();
        sio_stb = 1'b0;
        tick(6);
    endtask

    task automatic stb_hi();
        tick(4);
        sio_stb = 1'b1;
        tick(8);
    endtask

    task automatic sbits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sio_clk = 1'b0;
            sio_data_in = b[i];
            tick(6);
            sio_clk = 1'b1;
            tick(6);
        end
    endtask

    task automatic sbyte(input logic [7:0] b);
        sbits(b, 8);
    endtask

    task automatic sclks(input int n);
        for (int i = 0; i < n; i++) begin
            sio_clk = 1'b0;
            tick(6);
            sio_clk = 1'b1;
            tick(6);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) bit_q.push_back(v[i]);
    endtask

    initial begin
        logic [31:0] kv;

        // Reset state
        tick(3);
        chk("rst_ram", disp_ram, 128'd0);
        chk("rst_disp_on", {127'd0, disp_on}, 128'd0);
        chk("rst_bright", {125'd0, brightness}, 128'd0);
        chk("rst_oe", {127'd0, sio_data_oe}, 128'd0);
        chk("rst_dout", {127'd0, sio_data_out}, 128'd0);
        chk("rst_frame", {127'd0, frame_done}, 128'd0);
        rst = 1'b0;
        tick(6);

        // Write mode, then address 0 with two bytes
        stb_lo(); sbyte(8'h40); stb_hi();
        exp_ram[0] = 8'h3F; exp_ram[1] = 8'h06;
        frame_q.push_back(exp_ram);
        stb_lo(); sbyte(8'hC0); sbyte(8'h3F); sbyte(8'h06); stb_hi();
        chk("w0_ram", disp_ram, exp_ram);

        // Fixed address: both bytes land on address 5
        stb_lo(); sbyte(8'h44); stb_hi();
        exp_ram[5] = 8'h55;
        frame_q.push_back(exp_ram);
        stb_lo(); sbyte(8'hC5); sbyte(8'hAA); sbyte(8'h55); stb_hi();
        chk("fixed_byte6", {120'd0, disp_ram[55:48]}, 128'd0);

        // Auto-increment wrap 15 -> 0 -> 1
        stb_lo(); sbyte(8'h40); stb_hi();
        exp_ram[15] = 8'h11; exp_ram[0] = 8'h22; exp_ram[1] = 8'h33;
        frame_q.push_back(exp_ram);
        stb_lo(); sbyte(8'hCF); sbyte(8'h11); sbyte(8'h22); sbyte(8'h33); stb_hi();

        // Display control, then unknown command
        stb_lo(); sbyte(8'h8A); stb_hi();
        chk("ctl_on", {127'd0, disp_on}, 128'd1);
        chk("ctl_bright", {125'd0, brightness}, 128'd2);
        stb_lo(); sbyte(8'h00); stb_hi();
        chk("unk_on", {127'd0, disp_on}, 128'd1);
        chk("unk_bright", {125'd0, brightness}, 128'd2);
        chk("unk_ram", disp_ram, exp_ram);

        // Full key read; keys change after latching must not matter
        kv = 32'h8040_2001;
        keys = kv;
        push_bits(kv, 32);
        stb_lo(); sbyte(8'h42);
        keys = 32'h1234_5678;
        chk("rd_oe_before", {127'd0, sio_data_oe}, 128'd0);
        sclks(1);
        chk("rd_oe_during", {127'd0, sio_data_oe}, 128'd1);
        sclks(32);
        chk("rd_oe_after", {127'd0, sio_data_oe}, 128'd0);
        chk("rd_bits_left", 128'(bit_q.size()), 128'd0);
        stb_hi();

        // Partial write byte abandoned by strobe
        stb_lo(); sbyte(8'hC3); sbits(8'h1F, 5); stb_hi();
        chk("part_ram", disp_ram, exp_ram);
        chk("part_oe", {127'd0, sio_data_oe}, 128'd0);

        // Read aborted by strobe: oe drops within one clk of synced rise
        kv = 32'h0000_00A5;
        keys = kv;
        push_bits(kv, 3);
        stb_lo(); sbyte(8'h42); sclks(3);
        sio_clk = 1'b0;
        tick(6);
        chk("abort_oe_hi", {127'd0, sio_data_oe}, 128'd1);
        sio_stb = 1'b1;
        tick(3);
        chk("abort_oe_lo", {127'd0, sio_data_oe}, 128'd0);
        sio_clk = 1'b1;
        tick(8);

        // Read aborted by reset mid-transaction
        push_bits(kv, 2);
        stb_lo(); sbyte(8'h42); sclks(2);
        sio_clk = 1'b0;
        tick(6);
        chk("rst_rd_oe_hi", {127'd0, sio_data_oe}, 128'd1);
        rst = 1'b1;
        #1;
        chk("rst_rd_oe_lo", {127'd0, sio_data_oe}, 128'd0);
        chk("rst_rd_ram", disp_ram, 128'd0);
        chk("rst_rd_on", {127'd0, disp_on}, 128'd0);
        chk("rst_rd_bright", {125'd0, brightness}, 128'd0);
        exp_ram = '0;
        tick(3);
        rst = 1'b0;
        sio_clk = 1'b1;
        tick(6);
        // Strobe still low: these bytes must not be decoded
        sbyte(8'hC0); sbyte(8'h77);
        stb_hi();
        chk("post_rst_ignored", disp_ram, 128'd0);

        // Next transaction decodes normally
        exp_ram[2] = 8'h5A;
        frame_q.push_back(exp_ram);
        stb_lo(); sbyte(8'hC2); sbyte(8'h5A); stb_hi();
        chk("post_rst_ram", disp_ram, exp_ram);

        tick(10);
        chk("frames_left", 128'(frame_q.size()), 128'd0);
        chk("bits_left", 128'(bit_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
